stopwatch_ctrl: RTL and testbench

- Stopwatch controller: sequences a BCD millisecond/second/minute time chain from user pulses (start/stop, lap, clear).
- Generates the 1 ms tick from the system clock, owns the run/pause/lap state machine, and freezes the display on lap.
- Sits between the debounced button pulses and the 7-segment display driver.

---
 rtl/stopwatch_ctrl_pkg.sv | 32 +++
 rtl/stopwatch_ctrl_if.sv | 30 +++
 rtl/stopwatch_ctrl_bcd_digit.sv | 41 ++++
 rtl/stopwatch_ctrl.sv | 147 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller: state encoding, BCD digit
// limits, default timing and the packed display time layout.
package stopwatch_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } sw_state_e;

  localparam logic [3:0] BCD_LIMIT_UNITS = 4'd9;
  localparam logic [3:0] BCD_LIMIT_TENS6 = 4'd5;

  localparam int DEFAULT_CLK_PER_MS = 50000;
  localparam int DEFAULT_MIN_MAX    = 59;

  typedef struct packed {
    logic [11:0] ms;
    logic [7:0]  sec;
    logic [7:0]  min;
  } sw_time_t;

  // Two-digit BCD image of a binary value (0..99), used for the minute wrap compare.
  function automatic logic [7:0] to_bcd2(input int unsigned v);
    logic [7:0] r;
    r[7:4] = 4'((v / 10) % 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button/display bundle between the debounced buttons, the controller and the
// 7-segment driver; state_dbg exposes the controller FSM state.
interface stopwatch_ctrl_if;
  import stopwatch_defs::*;

  // Buttons are single-cycle pulses sampled on posedge clk; there is no
  // back-pressure, a pulse is either acted on or ignored in the cycle it is seen.
  logic        btn_start;
  logic        btn_lap;
  logic        btn_clear;
  logic [11:0] disp_ms;
  logic [7:0]  disp_sec;
  logic [7:0]  disp_min;
  logic        running;
  logic        lap_hold;
  logic        tick_1s;
  logic        ovf;
  sw_state_e   state_dbg;

  modport master (
    output btn_start, btn_lap, btn_clear,
    input  disp_ms, disp_sec, disp_min, running, lap_hold, tick_1s, ovf, state_dbg
  );

  modport slave (
    input  btn_start, btn_lap, btn_clear,
    output disp_ms, disp_sec, disp_min, running, lap_hold, tick_1s, ovf, state_dbg
  );

endinterface

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One BCD digit of the time chain: counts 0..LIMIT on inc, carries out as it
// wraps back to 0; clr has priority over inc.
module bcd_digit
  import stopwatch_defs::*;
#(
  parameter logic [3:0] LIMIT = BCD_LIMIT_UNITS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] value,
  output logic       carry
);

  logic [3:0] value_q;
  logic [3:0] value_d;
  logic       at_limit;

  assign at_limit = (value_q == LIMIT);
  assign carry    = inc && at_limit;
  assign value    = value_q;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = 4'd0;
    end else if (inc) begin
      value_d = at_limit ? 4'd0 : value_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= 4'd0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: 1 ms prescaler, run/pause/lap FSM, BCD mm:ss.mmm chain
// with a lap snapshot that freezes the display.
module stopwatch_ctrl
  import stopwatch_defs::*;
#(
  parameter int CLK_PER_MS = DEFAULT_CLK_PER_MS,
  parameter int MIN_MAX    = DEFAULT_MIN_MAX
) (
  input  logic             clk,
  input  logic             reset,
  stopwatch_ctrl_if.slave  sw
);

  localparam int             PW          = (CLK_PER_MS > 2) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0]  PRESC_LAST  = PW'(CLK_PER_MS - 1);
  localparam logic [7:0]     MIN_MAX_BCD = to_bcd2(MIN_MAX);

  sw_state_e     state_q;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic          running_q;
  logic          lap_hold_q;
  logic          tick_1s_q;
  logic          ovf_q;
  sw_time_t      snap_q;
  sw_time_t      live;

  logic          counting;
  logic          ms_tick;
  logic          clear_acc;
  logic          wrap;
  logic          dig_clr;
  logic [6:0]    dig_inc;
  logic [6:0]    dig_carry;
  logic [3:0]    ms0, ms1, ms2, sec0, sec1, min0, min1;

  assign counting  = (state_q == ST_RUN) || (state_q == ST_LAP);
  assign ms_tick   = counting && (presc_q == PRESC_LAST);
  assign clear_acc = (state_q == ST_PAUSE) && sw.btn_clear;

  // Past MIN_MAX:59.999 the whole chain restarts from zero; the min1 carry only
  // matters when MIN_MAX is 99, where the minute digits roll over by themselves.
  assign wrap    = (dig_carry[4] && ({min1, min0} == MIN_MAX_BCD)) || dig_carry[6];
  assign dig_clr = clear_acc || wrap;
  assign dig_inc = {dig_carry[5:0], ms_tick};

  bcd_digit #(.LIMIT(BCD_LIMIT_UNITS)) u_ms0 (
    .clk(clk), .reset(reset), .inc(dig_inc[0]), .clr(dig_clr), .value(ms0), .carry(dig_carry[0])
  );
  bcd_digit #(.LIMIT(BCD_LIMIT_UNITS)) u_ms1 (
    .clk(clk), .reset(reset), .inc(dig_inc[1]), .clr(dig_clr), .value(ms1), .carry(dig_carry[1])
  );
  bcd_digit #(.LIMIT(BCD_LIMIT_UNITS)) u_ms2 (
    .clk(clk), .reset(reset), .inc(dig_inc[2]), .clr(dig_clr), .value(ms2), .carry(dig_carry[2])
  );
  bcd_digit #(.LIMIT(BCD_LIMIT_UNITS)) u_sec0 (
    .clk(clk), .reset(reset), .inc(dig_inc[3]), .clr(dig_clr), .value(sec0), .carry(dig_carry[3])
  );
  bcd_digit #(.LIMIT(BCD_LIMIT_TENS6)) u_sec1 (
    .clk(clk), .reset(reset), .inc(dig_inc[4]), .clr(dig_clr), .value(sec1), .carry(dig_carry[4])
  );
  bcd_digit #(.LIMIT(BCD_LIMIT_UNITS)) u_min0 (
    .clk(clk), .reset(reset), .inc(dig_inc[5]), .clr(dig_clr), .value(min0), .carry(dig_carry[5])
  );
  bcd_digit #(.LIMIT(BCD_LIMIT_UNITS)) u_min1 (
    .clk(clk), .reset(reset), .inc(dig_inc[6]), .clr(dig_clr), .value(min1), .carry(dig_carry[6])
  );

  assign live = {ms2, ms1, ms0, sec1, sec0, min1, min0};

  // Pause keeps the partial millisecond so resuming does not lose time.
  always_comb begin
    presc_d = presc_q;
    if (clear_acc || ms_tick) begin
      presc_d = '0;
    end else if (counting) begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      running_q  <= 1'b0;
      lap_hold_q <= 1'b0;
      tick_1s_q  <= 1'b0;
      ovf_q      <= 1'b0;
      snap_q     <= '0;
    end else begin
      presc_q   <= presc_d;
      tick_1s_q <= dig_carry[2];
      if (clear_acc) begin
        ovf_q <= 1'b0;
      end else if (wrap) begin
        ovf_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (sw.btn_start) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (sw.btn_start) begin
            state_q   <= ST_PAUSE;
            running_q <= 1'b0;
          end else if (sw.btn_lap) begin
            state_q    <= ST_LAP;
            lap_hold_q <= 1'b1;
            snap_q     <= live;
          end
        end
        ST_LAP: begin
          if (sw.btn_start) begin
            state_q    <= ST_PAUSE;
            running_q  <= 1'b0;
            lap_hold_q <= 1'b0;
          end else if (sw.btn_lap) begin
            state_q    <= ST_RUN;
            lap_hold_q <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (sw.btn_clear) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
          end else if (sw.btn_start) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign sw.disp_ms   = lap_hold_q ? snap_q.ms  : live.ms;
  assign sw.disp_sec  = lap_hold_q ? snap_q.sec : live.sec;
  assign sw.disp_min  = lap_hold_q ? snap_q.min : live.min;
  assign sw.running   = running_q;
  assign sw.lap_hold  = lap_hold_q;
  assign sw.tick_1s   = tick_1s_q;
  assign sw.ovf       = ovf_q;
  assign sw.state_dbg = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed steps plus random button traffic, checked
// against an elapsed-milliseconds model of the stopwatch.
module tb_stopwatch_ctrl;
  import stopwatch_defs::*;

  localparam int CPM    = 4;
  localparam int MINMAX = 1;
  localparam int MODMS  = (MINMAX + 1) * 60000;

  typedef enum int {MD_IDLE, MD_RUNNING, MD_PAUSED, MD_LAPPED} md_e;

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(.CLK_PER_MS(CPM), .MIN_MAX(MINMAX)) dut (
    .clk  (clk),
    .reset(reset),
    .sw   (sw_if)
  );

  // reference model: elapsed time as a plain millisecond count
  md_e m_mode   = MD_IDLE;
  int  m_sub    = 0;
  int  m_total  = 0;
  int  m_snap   = 0;
  bit  m_ovf    = 1'b0;
  bit  m_tick1s = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  function automatic logic [27:0] time_bcd(input int t);
    int ms, s, m;
    ms = t % 1000;
    s  = (t / 1000) % 60;
    m  = t / 60000;
    return {4'(ms / 100), 4'((ms / 10) % 10), 4'(ms % 10),
            4'(s / 10), 4'(s % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  function automatic logic [31:0] exp_vec();
    logic run_o, lap_o;
    run_o = (m_mode == MD_RUNNING) || (m_mode == MD_LAPPED);
    lap_o = (m_mode == MD_LAPPED);
    return {time_bcd(lap_o ? m_snap : m_total), run_o, lap_o, m_tick1s, m_ovf};
  endfunction

  function automatic logic [31:0] obs_vec();
    return {sw_if.disp_ms, sw_if.disp_sec, sw_if.disp_min,
            sw_if.running, sw_if.lap_hold, sw_if.tick_1s, sw_if.ovf};
  endfunction

  function automatic void model_step(input bit s, input bit l, input bit c, input bit r);
    bit counting, tick;
    int old_total;
    if (r) begin
      m_mode = MD_IDLE; m_sub = 0; m_total = 0; m_snap = 0; m_ovf = 0; m_tick1s = 0;
      return;
    end
    counting  = (m_mode == MD_RUNNING) || (m_mode == MD_LAPPED);
    tick      = counting && (m_sub == CPM - 1);
    old_total = m_total;
    m_tick1s  = 1'b0;
    if (tick) begin
      m_total = m_total + 1;
      if (m_total == MODMS) begin
        m_total = 0;
        m_ovf   = 1'b1;
      end
      if (m_total % 1000 == 0) m_tick1s = 1'b1;
    end
    if (counting) m_sub = tick ? 0 : m_sub + 1;
    case (m_mode)
      MD_IDLE:    if (s) m_mode = MD_RUNNING;
      MD_RUNNING: if (s) m_mode = MD_PAUSED;
                  else if (l) begin m_mode = MD_LAPPED; m_snap = old_total; end
      MD_LAPPED:  if (s) m_mode = MD_PAUSED;
                  else if (l) m_mode = MD_RUNNING;
      MD_PAUSED:  if (c) begin
                    m_mode = MD_IDLE; m_sub = 0; m_total = 0; m_snap = 0; m_ovf = 0;
                  end else if (s) m_mode = MD_RUNNING;
    endcase
  endfunction

  // scoreboard compare
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // driver: one clock cycle with the given button pulses and reset
  task automatic step(input bit s = 0, input bit l = 0, input bit c = 0, input bit r = 0,
                      input string tag = "cycle");
    @(negedge clk);
    sw_if.btn_start = s;
    sw_if.btn_lap   = l;
    sw_if.btn_clear = c;
    reset           = r;
    model_step(s, l, c, r);
    exp_q.push_back(exp_vec());
    @(posedge clk);
    #1;
    sw_if.btn_start = 1'b0;
    sw_if.btn_lap   = 1'b0;
    sw_if.btn_clear = 1'b0;
    reset           = 1'b0;
    check(tag, obs_vec(), exp_q.pop_front());
  endtask

  function automatic logic [31:0] obs_time();
    return {4'h0, sw_if.disp_ms, sw_if.disp_sec, sw_if.disp_min};
  endfunction

  function automatic logic [31:0] obs_flags();
    return {28'h0, sw_if.running, sw_if.lap_hold, sw_if.tick_1s, sw_if.ovf};
  endfunction

  initial begin
    int n_tick;
    bit rs, rl, rc, rr;
    sw_if.btn_start = 1'b0;
    sw_if.btn_lap   = 1'b0;
    sw_if.btn_clear = 1'b0;

    // reset state
    step(0, 0, 0, 1, "reset");
    step(0, 0, 0, 1, "reset");
    check("reset_state", obs_vec(), 32'h0);

    // 1: one second of running
    step(1, 0, 0, 0, "t1_start");
    n_tick = 0;
    for (int i = 0; i < 4000; i++) begin
      step(0, 0, 0, 0, "t1_run");
      if (sw_if.tick_1s) n_tick++;
    end
    check("t1_time", obs_time(), {4'h0, 12'h000, 8'h01, 8'h00});
    check("t1_tick_count", 32'(n_tick), 32'd1);
    check("t1_flags", obs_flags(), 32'b1010);

    // 2: pause keeps the partial millisecond
    step(0, 0, 0, 1, "t2_reset");
    step(1, 0, 0, 0, "t2_start");
    repeat (18) step(0, 0, 0, 0, "t2_run");
    step(1, 0, 0, 0, "t2_pause");
    repeat (100) step(0, 0, 0, 0, "t2_paused");
    step(1, 0, 0, 0, "t2_resume");
    repeat (2) step(0, 0, 0, 0, "t2_run2");
    check("t2_ms", obs_time(), {4'h0, 12'h005, 8'h00, 8'h00});

    // 3: lap freezes the display while counting continues
    step(0, 0, 0, 1, "t3_reset");
    step(1, 0, 0, 0, "t3_start");
    repeat (492) step(0, 0, 0, 0, "t3_run");
    check("t3_pre_lap", obs_time(), {4'h0, 12'h123, 8'h00, 8'h00});
    step(0, 1, 0, 0, "t3_lap");
    check("t3_lap_flags", obs_flags(), 32'b1100);
    repeat (200) step(0, 0, 0, 0, "t3_lap_run");
    check("t3_frozen", obs_time(), {4'h0, 12'h123, 8'h00, 8'h00});
    repeat (200) step(0, 0, 0, 0, "t3_lap_run");
    step(0, 1, 0, 0, "t3_release");
    check("t3_live", {obs_time()[27:0], sw_if.running, sw_if.lap_hold, 2'b00},
          {12'h223, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00});

    // 4: clear ignored in RUN, honoured in PAUSE
    step(0, 0, 1, 0, "t4_clear_run");
    check("t4_clear_ignored", obs_time(), {4'h0, 12'h223, 8'h00, 8'h00});
    step(1, 0, 0, 0, "t4_pause");
    check("t4_tick_on_pause", {obs_time()[27:0], obs_flags()[3:0]}, {12'h224, 16'h0, 4'b0000});
    step(0, 0, 1, 0, "t4_clear");
    check("t4_idle", obs_vec(), 32'h0);

    // 5: overflow from MIN_MAX:59.999 using a preloaded chain
    step(0, 0, 0, 1, "t5_reset");
    step(1, 0, 0, 0, "t5_start");
    step(1, 0, 0, 0, "t5_pause");
    force dut.u_ms0.value_q  = 4'd9;
    force dut.u_ms1.value_q  = 4'd9;
    force dut.u_ms2.value_q  = 4'd9;
    force dut.u_sec0.value_q = 4'd9;
    force dut.u_sec1.value_q = 4'd5;
    force dut.u_min0.value_q = 4'd1;
    force dut.u_min1.value_q = 4'd0;
    m_total = MODMS - 1;
    step(0, 0, 0, 0, "t5_preload");
    release dut.u_ms0.value_q;
    release dut.u_ms1.value_q;
    release dut.u_ms2.value_q;
    release dut.u_sec0.value_q;
    release dut.u_sec1.value_q;
    release dut.u_min0.value_q;
    release dut.u_min1.value_q;
    check("t5_max_time", obs_time(), {4'h0, 12'h999, 8'h59, 8'h01});
    step(1, 0, 0, 0, "t5_resume");
    repeat (3) step(0, 0, 0, 0, "t5_run");
    check("t5_wrap", obs_vec(), 32'h0000000B);
    repeat (40) step(0, 0, 0, 0, "t5_after");
    check("t5_ovf_sticky", 32'(sw_if.ovf), 32'd1);
    step(1, 0, 0, 0, "t5_pause2");
    step(0, 0, 1, 0, "t5_clear");
    check("t5_ovf_cleared", obs_vec(), 32'h0);

    // 6: clear beats start in PAUSE; reset beats a button mid-lap
    step(0, 0, 0, 1, "t6_reset");
    step(1, 0, 0, 0, "t6_start");
    repeat (10) step(0, 0, 0, 0, "t6_run");
    step(1, 0, 0, 0, "t6_pause");
    step(1, 0, 1, 0, "t6_start_clear");
    check("t6_clear_wins", obs_vec(), 32'h0);
    step(1, 0, 0, 0, "t6_start2");
    repeat (30) step(0, 0, 0, 0, "t6_run2");
    step(0, 1, 0, 0, "t6_lap");
    repeat (10) step(0, 0, 0, 0, "t6_lap_run");
    step(1, 0, 0, 1, "t6_reset_mid_lap");
    check("t6_reset_outputs", obs_vec(), 32'h0);

    // random button traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rs = ($urandom_range(0, 39) == 0);
      rl = ($urandom_range(0, 29) == 0);
      rc = ($urandom_range(0, 24) == 0);
      rr = ($urandom_range(0, 999) == 0);
      step(rs, rl, rc, rr, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
